// File: rtl/pulp_cluster_package.sv
// Shared cluster types for the core data ports, plus constants and helpers
// for the round-robin data-port arbiter.
package pulp_cluster_package;

    localparam int unsigned DATA_ARB_MAX_OUTSTANDING = 32'd4;

    typedef struct packed {
        logic        req;
        logic [31:0] add;
        logic        wen;
        logic [31:0] data;
        logic [3:0]  be;
    } core_data_req_t;

    typedef struct packed {
        logic        gnt;
        logic [31:0] r_data;
        logic        r_valid;
    } core_data_rsp_t;

    localparam core_data_req_t DATA_REQ_IDLE = '{default: 1'b0};
    localparam core_data_rsp_t DATA_RSP_IDLE = '{default: 1'b0};

    // Cyclic index: k steps after start in a ring of n entries.
    function automatic int unsigned rr_idx(input int unsigned start,
                                           input int unsigned k,
                                           input int unsigned n);
        return (start + k) % n;
    endfunction

    // Pointer width that stays legal for a depth of one.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 32'd1) ? $clog2(depth) : 32'd1;
    endfunction

endpackage

// File: rtl/core_data_arb_idfifo.sv
// In-order FIFO of requester indices for granted, not yet answered transactions.
// Full and empty derive from the registered occupancy count only.
module core_data_arb_idfifo
    import pulp_cluster_package::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign full_o    = (count_r == CNT_FULL);
    assign empty_o   = (count_r == {CNT_W{1'b0}});
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;
    assign data_o    = mem_r[rd_ptr_r];

    // Entry storage; contents are only meaningful between push and pop.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/core_data_arbiter.sv
// Round-robin arbiter sharing one cluster data port among NB_REQ requesters,
// with in-order response routing. Option: DATA_ARB_FIXED_PRIO_EN gives requester 0 fixed priority.
module core_data_arbiter
    import pulp_cluster_package::*;
#(
    parameter int unsigned NB_REQ          = 4,
    parameter int unsigned MAX_OUTSTANDING = DATA_ARB_MAX_OUTSTANDING
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  core_data_req_t req_i [NB_REQ],
    output core_data_rsp_t rsp_o [NB_REQ],
    output core_data_req_t req_o,
    input  core_data_rsp_t rsp_i,
    output logic           resp_err_o
);

    localparam int unsigned IDX_W = $clog2(NB_REQ);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB_REQ - 1);

    logic [NB_REQ-1:0] eligible_s;
    logic              found_s;
    logic [IDX_W-1:0]  win_s;
    logic [IDX_W-1:0]  rr_ptr_r;
    logic [IDX_W-1:0]  rr_ptr_nxt_s;
    logic              handshake_s;
    logic              pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [IDX_W-1:0]  head_s;

    // Eligibility: a full FIFO blocks everyone, even if it pops this cycle.
    always_comb begin
        eligible_s = {NB_REQ{1'b0}};
        for (int i = 0; i < NB_REQ; i++) begin
            eligible_s[i] = req_i[i].req & ~fifo_full_s;
        end
    end

`ifdef DATA_ARB_FIXED_PRIO_EN
    int unsigned rr_base_s;

    assign rr_base_s = (rr_ptr_r == {IDX_W{1'b0}}) ? 32'd1 : 32'(rr_ptr_r);

    // Requester 0 first, then a round-robin scan over indices 1..NB_REQ-1.
    always_comb begin
        found_s = eligible_s[0];
        win_s   = {IDX_W{1'b0}};
        for (int k = 0; k < NB_REQ - 1; k++) begin
            win_s   = (~found_s & eligible_s[32'd1 + rr_idx(rr_base_s - 32'd1, k, NB_REQ - 1)])
                    ? IDX_W'(32'd1 + rr_idx(rr_base_s - 32'd1, k, NB_REQ - 1)) : win_s;
            found_s = found_s | eligible_s[32'd1 + rr_idx(rr_base_s - 32'd1, k, NB_REQ - 1)];
        end
    end

    // Pointer never lands on 0; grants to requester 0 leave it untouched.
    always_comb begin
        if (win_s == {IDX_W{1'b0}}) begin
            rr_ptr_nxt_s = rr_ptr_r;
        end else if (win_s == IDX_LAST) begin
            rr_ptr_nxt_s = IDX_W'(1);
        end else begin
            rr_ptr_nxt_s = win_s + IDX_W'(1);
        end
    end
`else
    // First eligible index at or after rr_ptr, cyclically.
    always_comb begin
        found_s = 1'b0;
        win_s   = {IDX_W{1'b0}};
        for (int k = 0; k < NB_REQ; k++) begin
            win_s   = (~found_s & eligible_s[rr_idx(32'(rr_ptr_r), k, NB_REQ)])
                    ? IDX_W'(rr_idx(32'(rr_ptr_r), k, NB_REQ)) : win_s;
            found_s = found_s | eligible_s[rr_idx(32'(rr_ptr_r), k, NB_REQ)];
        end
    end

    // Next pointer sits just past the winner.
    always_comb begin
        if (win_s == IDX_LAST) begin
            rr_ptr_nxt_s = {IDX_W{1'b0}};
        end else begin
            rr_ptr_nxt_s = win_s + IDX_W'(1);
        end
    end
`endif

    assign handshake_s = found_s & rsp_i.gnt;
    assign pop_s       = rsp_i.r_valid & ~fifo_empty_s;
    assign resp_err_o  = rsp_i.r_valid & fifo_empty_s;

    // Forward the winner's request to the shared slave.
    always_comb begin
        req_o = DATA_REQ_IDLE;
        if (found_s) begin
            req_o     = req_i[win_s];
            req_o.req = 1'b1;
        end else begin
            req_o = DATA_REQ_IDLE;
        end
    end

    // Grant to the winner only; response data goes to the FIFO head only.
    always_comb begin
        for (int i = 0; i < NB_REQ; i++) begin
            rsp_o[i]         = DATA_RSP_IDLE;
            rsp_o[i].gnt     = found_s & (win_s == IDX_W'(i)) & rsp_i.gnt;
            rsp_o[i].r_valid = pop_s & (head_s == IDX_W'(i));
            rsp_o[i].r_data  = (pop_s & (head_s == IDX_W'(i))) ? rsp_i.r_data : 32'h0000_0000;
        end
    end

    // Round-robin pointer advances only on a completed handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_r <= {IDX_W{1'b0}};
        end else if (handshake_s) begin
            rr_ptr_r <= rr_ptr_nxt_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    core_data_arb_idfifo #(
        .DEPTH  (MAX_OUTSTANDING),
        .DATA_W (IDX_W)
    ) u_idfifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (handshake_s),
        .data_i  (win_s),
        .pop_i   (pop_s),
        .data_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

endmodule

// File: tb/tb_core_data_arbiter.sv
// Directed table-driven bench for core_data_arbiter (NB_REQ=4, MAX_OUTSTANDING=4, round-robin build).
module tb_core_data_arbiter;
    import pulp_cluster_package::*;

    localparam int unsigned NB_REQ  = 4;
    localparam int unsigned MAX_OUT = 4;

    logic           clk_s = 1'b0;
    logic           rst_s;
    core_data_req_t req_s [NB_REQ];
    core_data_rsp_t rsp_s [NB_REQ];
    core_data_req_t slv_req_s;
    core_data_rsp_t slv_rsp_s;
    logic           resp_err_s;

    int checks;
    int errors;

    logic [31:0] add_tab [NB_REQ];

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        exp_req;
        int          exp_win;
        logic [3:0]  exp_gnt;
        logic [3:0]  exp_rv;
        logic        exp_err;
    } vec_t;

    vec_t vecs [$];

    always #5 clk_s = ~clk_s;

    core_data_arbiter #(
        .NB_REQ          (NB_REQ),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk_i      (clk_s),
        .rst_i      (rst_s),
        .req_i      (req_s),
        .rsp_o      (rsp_s),
        .req_o      (slv_req_s),
        .rsp_i      (slv_rsp_s),
        .resp_err_o (resp_err_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] req, input logic gnt, input logic rv,
                       input logic [31:0] rdata, input logic exp_req, input int exp_win,
                       input logic [3:0] exp_gnt, input logic [3:0] exp_rv, input logic exp_err);
        vec_t v;
        v.rst = rst; v.req = req; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.exp_req = exp_req; v.exp_win = exp_win; v.exp_gnt = exp_gnt;
        v.exp_rv = exp_rv; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    task automatic apply_and_check(input vec_t v, input int row);
        logic [3:0] gnt_m;
        logic [3:0] rv_m;
        rst_s = v.rst;
        for (int i = 0; i < NB_REQ; i++) begin
            req_s[i].req = v.req[i];
        end
        slv_rsp_s.gnt     = v.gnt;
        slv_rsp_s.r_valid = v.rv;
        slv_rsp_s.r_data  = v.rdata;
        #1;
        gnt_m = 4'b0000;
        rv_m  = 4'b0000;
        for (int i = 0; i < NB_REQ; i++) begin
            gnt_m[i] = rsp_s[i].gnt;
            rv_m[i]  = rsp_s[i].r_valid;
        end
        check($sformatf("row%0d req_o.req", row), {31'd0, slv_req_s.req}, {31'd0, v.exp_req});
        if (v.exp_req) begin
            check($sformatf("row%0d req_o.add", row), slv_req_s.add, add_tab[v.exp_win]);
            check($sformatf("row%0d req_o.data", row), slv_req_s.data, 32'hD000_0000 | v.exp_win);
            check($sformatf("row%0d req_o.wen", row), {31'd0, slv_req_s.wen}, {31'd0, (v.exp_win != 2)});
        end else begin
            check($sformatf("row%0d req_o.idle", row), {31'd0, (slv_req_s == DATA_REQ_IDLE)}, 32'd1);
        end
        check($sformatf("row%0d gnt_mask", row), {28'd0, gnt_m}, {28'd0, v.exp_gnt});
        check($sformatf("row%0d rvalid_mask", row), {28'd0, rv_m}, {28'd0, v.exp_rv});
        for (int i = 0; i < NB_REQ; i++) begin
            check($sformatf("row%0d r_data[%0d]", row, i), rsp_s[i].r_data,
                  v.exp_rv[i] ? v.rdata : 32'h0000_0000);
        end
        check($sformatf("row%0d resp_err", row), {31'd0, resp_err_s}, {31'd0, v.exp_err});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        add_tab[0] = 32'h1000_0000;
        add_tab[1] = 32'h1000_0004;
        add_tab[2] = 32'h1000_0010;
        add_tab[3] = 32'h1000_000C;
        rst_s = 1'b1;
        for (int i = 0; i < NB_REQ; i++) begin
            req_s[i].req  = 1'b0;
            req_s[i].add  = add_tab[i];
            req_s[i].wen  = (i != 2);
            req_s[i].data = 32'hD000_0000 | i;
            req_s[i].be   = 4'hF;
        end
        slv_rsp_s = DATA_RSP_IDLE;

        //   rst  req     gnt  rv    rdata        ereq win egnt     erv      err
        add(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0,      1'b0, 0, 4'b0000, 4'b0000, 1'b0); // reset
        add(1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,      1'b0, 0, 4'b0000, 4'b0000, 1'b0);
        add(1'b0, 4'b0100, 1'b1, 1'b0, 32'h0,      1'b1, 2, 4'b0100, 4'b0000, 1'b0); // store from 2
        add(1'b0, 4'b0000, 1'b0, 1'b1, 32'h55,     1'b0, 0, 4'b0000, 4'b0100, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 1'b0, 32'h0,      1'b1, 3, 4'b1000, 4'b0000, 1'b0); // all request
        add(1'b0, 4'b1111, 1'b1, 1'b1, 32'hA0,     1'b1, 0, 4'b0001, 4'b1000, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 1'b1, 32'hA1,     1'b1, 1, 4'b0010, 4'b0001, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 1'b1, 32'hA2,     1'b1, 2, 4'b0100, 4'b0010, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 1'b1, 32'hA3,     1'b1, 3, 4'b1000, 4'b0100, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 1'b1, 32'hA4,     1'b1, 0, 4'b0001, 4'b1000, 1'b0);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 32'hA5,     1'b0, 0, 4'b0000, 4'b0001, 1'b0);
        add(1'b0, 4'b1010, 1'b0, 1'b0, 32'h0,      1'b1, 1, 4'b0000, 4'b0000, 1'b0); // stall
        add(1'b0, 4'b1010, 1'b0, 1'b0, 32'h0,      1'b1, 1, 4'b0000, 4'b0000, 1'b0);
        add(1'b0, 4'b1010, 1'b0, 1'b0, 32'h0,      1'b1, 1, 4'b0000, 4'b0000, 1'b0);
        add(1'b0, 4'b1010, 1'b1, 1'b0, 32'h0,      1'b1, 1, 4'b0010, 4'b0000, 1'b0);
        add(1'b0, 4'b1010, 1'b1, 1'b0, 32'h0,      1'b1, 3, 4'b1000, 4'b0000, 1'b0);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 32'hB1,     1'b0, 0, 4'b0000, 4'b0010, 1'b0);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 32'hB3,     1'b0, 0, 4'b0000, 4'b1000, 1'b0);
        add(1'b0, 4'b0001, 1'b1, 1'b0, 32'h0,      1'b1, 0, 4'b0001, 4'b0000, 1'b0); // fill
        add(1'b0, 4'b0001, 1'b1, 1'b0, 32'h0,      1'b1, 0, 4'b0001, 4'b0000, 1'b0);
        add(1'b0, 4'b0001, 1'b1, 1'b0, 32'h0,      1'b1, 0, 4'b0001, 4'b0000, 1'b0);
        add(1'b0, 4'b0001, 1'b1, 1'b0, 32'h0,      1'b1, 0, 4'b0001, 4'b0000, 1'b0);
        add(1'b0, 4'b0001, 1'b1, 1'b0, 32'h0,      1'b0, 0, 4'b0000, 4'b0000, 1'b0); // full
        add(1'b0, 4'b0001, 1'b1, 1'b1, 32'hC0,     1'b0, 0, 4'b0000, 4'b0001, 1'b0); // pop while full
        add(1'b0, 4'b0001, 1'b1, 1'b0, 32'h0,      1'b1, 0, 4'b0001, 4'b0000, 1'b0);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 32'hC1,     1'b0, 0, 4'b0000, 4'b0001, 1'b0);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 32'hC2,     1'b0, 0, 4'b0000, 4'b0001, 1'b0);
        add(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0,      1'b0, 0, 4'b0000, 4'b0000, 1'b0); // reset, 2 left
        add(1'b0, 4'b0000, 1'b0, 1'b1, 32'hEE,     1'b0, 0, 4'b0000, 4'b0000, 1'b1); // stray
        add(1'b0, 4'b0010, 1'b1, 1'b0, 32'h0,      1'b1, 1, 4'b0010, 4'b0000, 1'b0); // 1,0,2
        add(1'b0, 4'b0001, 1'b1, 1'b0, 32'h0,      1'b1, 0, 4'b0001, 4'b0000, 1'b0);
        add(1'b0, 4'b0100, 1'b1, 1'b1, 32'hA,      1'b1, 2, 4'b0100, 4'b0010, 1'b0);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 32'hB,      1'b0, 0, 4'b0000, 4'b0001, 1'b0);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 32'hC,      1'b0, 0, 4'b0000, 4'b0100, 1'b0);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 32'hD,      1'b0, 0, 4'b0000, 4'b0000, 1'b1);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,      1'b0, 0, 4'b0000, 4'b0000, 1'b0);

        for (int r = 0; r < vecs.size(); r++) begin
            @(negedge clk_s);
            apply_and_check(vecs[r], r);
        end

        // Streaming sequence: requesters 2 and 3 alternate, slave answers one cycle after each grant.
        begin
            vec_t v;
            int   prev_win;
            prev_win = 0;
            for (int k = 0; k < 6; k++) begin
                v.rst     = 1'b0;
                v.req     = 4'b1100;
                v.gnt     = 1'b1;
                v.rv      = (k > 0);
                v.rdata   = 32'hF0 + k;
                v.exp_req = 1'b1;
                v.exp_win = (k % 2 == 0) ? 3 : 2;
                v.exp_gnt = 4'b0001 << v.exp_win;
                v.exp_rv  = (k > 0) ? (4'b0001 << prev_win) : 4'b0000;
                v.exp_err = 1'b0;
                @(negedge clk_s);
                apply_and_check(v, 100 + k);
                prev_win = v.exp_win;
            end
            v.req     = 4'b0000;
            v.gnt     = 1'b0;
            v.rv      = 1'b1;
            v.rdata   = 32'hFF;
            v.exp_req = 1'b0;
            v.exp_win = 0;
            v.exp_gnt = 4'b0000;
            v.exp_rv  = 4'b0001 << prev_win;
            @(negedge clk_s);
            apply_and_check(v, 106);
        end

        @(negedge clk_s);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
